instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit feeding the instruction decoder. Holds the program counter, issues word reads to instruction memory over a request/grant/response handshake, buffers returned words with their PC in a 2-entry queue, and presents them to the decoder over a valid/ready interface. Branch/jump resolution redirects the PC, flushing buffered and in-flight words.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, max words outstanding plus buffered (queue entries)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request
- imem_addr  out  32  word address, bits [1:0] always 0
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant
- imem_rdata  in  32  response word
- instr_valid  out  1  instr/instr_pc valid to decoder
- instr  out  32  instruction word
- instr_pc  out  32  PC of instr
- instr_ready  in  1  decoder accepts
- redirect  in  1  PC redirect (taken branch, JAL, JALR)
- redirect_pc  in  32  target; bits [1:0] forced to 0

## Operation
- Reset values: imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 32'h0000_0013 (NOP), instr_pc 0; fetch_pc = RESET_PC, queue empty, outstanding 0, kill_cnt 0.
- Credit: imem_req = 1 when outstanding + queue_count < DEPTH and not redirect. imem_addr = fetch_pc. On req && gnt: outstanding++, fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0).
- Once asserted, req and addr hold until gnt, except on redirect.
- Response: rvalid with kill_cnt == 0 → push {imem_rdata, pc} into queue, outstanding--. Response PC tracked by an internal response-PC register advanced by 4 per accepted response.
- Response with kill_cnt > 0 → dropped, kill_cnt--, outstanding--.
- Output: head of queue; pop on instr_valid && instr_ready.
- Redirect: queue flushed; fetch_pc and response-PC ← redirect_pc & ~3; kill_cnt ← outstanding after same-cycle grant/response accounting (granted request counts, dropped/returned response does not); imem_req forced 0 that cycle; new fetch issued next cycle.
- instr_valid forced 0 in any cycle redirect is high (no transfer occurs).
- Queue full never occurs with rvalid: credit rule guarantees space. rvalid with outstanding == 0 is a protocol error; ignored.

## Timing
- Reset release → imem_req high on first clk edge after rst_n rises.
- Response at cycle N → instr_valid at N+1 (registered queue output), unless bypass (see Configuration).
- Steady state with single-cycle memory and instr_ready held high: one instruction per cycle.
- Redirect at cycle R → imem_req with new address at R+1; first new instr_valid no earlier than R+3 (R+2 with bypass).
- Reset mid-operation: all state returns to reset values immediately; late responses after release are not possible by system contract.

## Configuration
- IFETCH_BYPASS_EN defined: when queue is empty and a non-killed response arrives, it is presented on instr/instr_pc with instr_valid in the same cycle; if instr_ready is high it is consumed without entering the queue, else it is pushed.
- Undefined: all responses pass through the queue; one-cycle minimum response-to-valid latency.

## Structure
- Shared package: RESET_PC default, NOP constant 32'h0000_0013, XLEN = 32, PC increment 4.
- Sub-module fetch_queue: parametric DEPTH FIFO of {pc, instr} with push, pop, flush, count, empty, full.

## Test plan
- Reset, RESET_PC 0, 1-cycle memory returning addr+32'h100, instr_ready 1 → instr_pc 0,4,8,… with instr 32'h100,32'h104,… one per cycle.
- instr_ready held 0 → after 2 responses imem_req stays 0; queue holds PCs 0,4; raising ready drains them in order then fetch resumes at 8.
- Redirect to 32'h0000_0203 with 2 outstanding → both responses dropped, next imem_addr 32'h200, next instr_pc 32'h200.
- Redirect coincident with gnt of addr 8 and rvalid for addr 4 → both discarded, kill_cnt 1 after edge, no instr_valid until 32'h…target arrives.
- fetch_pc 32'hFFFF_FFFC granted → next imem_addr 0.
- rst_n low mid-fetch with queue full → outputs at reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared constants and the buffered fetch entry type
package instr_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory request/grant/response bus
interface instr_fetch_if;
  import instr_fetch_pkg::*;
  logic imem_req;
  logic [XLEN-1:0] imem_addr;
  logic imem_gnt;
  logic imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_queue.sv
// fetch_queue: DEPTH-entry FIFO of {pc, instr} with synchronous flush
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  fetch_entry_t din,
  input  logic pop,
  input  logic flush,
  output fetch_entry_t dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic empty,
  output logic full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // Pointers, occupancy and storage; flush empties the FIFO without clearing stored words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: '0, instr: NOP};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-limited imem fetch, 2-entry buffer and redirect flush; define IFETCH_BYPASS_EN for same-cycle response bypass
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_if.master imem,
  output logic instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic instr_ready,
  input  logic redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  logic run, req_int, grant, resp, resp_live, q_push, q_pop, q_empty, q_full;
  logic [CW-1:0] outstanding, kill_cnt, q_count, out_nxt;
  logic [XLEN-1:0] fetch_pc, resp_pc, target;
  fetch_entry_t q_head, q_din;
  assign target = redirect_pc & ~32'h3;
  // A same-cycle pop frees its slot so a single-cycle memory sustains one instruction per cycle
  assign req_int = run && ({1'b0, outstanding} + {1'b0, q_count} - {{CW{1'b0}}, q_pop} < (CW+1)'(DEPTH));
  assign imem.imem_req = req_int && !redirect;
  assign imem.imem_addr = fetch_pc;
  assign grant = req_int && imem.imem_gnt;
  assign resp = imem.imem_rvalid && outstanding != '0;
  assign resp_live = resp && kill_cnt == '0;
  assign out_nxt = outstanding + CW'(grant) - CW'(resp);
  assign q_din.pc = resp_pc;
  assign q_din.instr = imem.imem_rdata;
`ifdef IFETCH_BYPASS_EN
  logic bypass;
  assign bypass = resp_live && q_empty;
  assign instr_valid = (bypass || !q_empty) && !redirect;
  assign instr = bypass ? imem.imem_rdata : q_head.instr;
  assign instr_pc = bypass ? resp_pc : q_head.pc;
  assign q_push = resp_live && !q_full && !(bypass && instr_ready);
`else
  assign instr_valid = !q_empty && !redirect;
  assign instr = q_head.instr;
  assign instr_pc = q_head.pc;
  assign q_push = resp_live && !q_full;
`endif
  assign q_pop = instr_valid && instr_ready && !q_empty;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst_n(rst_n), .push(q_push), .din(q_din), .pop(q_pop), .flush(redirect),
    .dout(q_head), .count(q_count), .empty(q_empty), .full(q_full)
  );
  // PC tracking, outstanding accounting and kill of responses in flight across a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      kill_cnt <= '0;
    end else begin
      run <= 1'b1;
      outstanding <= out_nxt;
      if (redirect) begin
        fetch_pc <= target;
        resp_pc <= target;
        kill_cnt <= out_nxt;
      end else begin
        if (grant) fetch_pc <= fetch_pc + PC_INC;
        if (resp_live) resp_pc <= resp_pc + PC_INC;
        if (resp && kill_cnt != '0) kill_cnt <= kill_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized memory/decoder/redirect stimulus with scoreboard of expected {pc, instr}
module tb_instr_fetch;
  import instr_fetch_pkg::*;
  typedef struct { logic [31:0] pc; logic [31:0] word; } exp_t;
  typedef struct { logic [31:0] addr; bit live; int due; } mreq_t;
  logic clk = 1'b0, rst_n = 1'b0, instr_valid, instr_ready = 1'b0, redirect = 1'b0;
  logic [31:0] instr, instr_pc, redirect_pc = '0;
  exp_t exp_q[$];
  mreq_t mem_q[$];
  int n_tests = 0, n_fail = 0, cyc = 0, hs_cnt = 0, snap = 0;
  int rdy_pct = 100, gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] mdl_pc = '0;
  bit pend = 1'b0;
  instr_fetch_if bus();
  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a + 32'h100) ^ 32'hC3C3_0000;
  endfunction
  function void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction
  // Monitor: every decoder transfer must match the oldest expected fetch
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst_n && instr_valid && instr_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %h, expected no transfer", instr_pc);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr", instr, e.word);
      end
    end
  end
  task automatic cycle(input bit rdr, input logic [31:0] tgt);
    int live;
    @(negedge clk);
    redirect = rdr;
    redirect_pc = tgt;
    instr_ready = $urandom_range(100, 1) <= rdy_pct;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = mem_word(mem_q[0].addr);
      end
    end
    #1;
    bus.imem_gnt = (rdr ? pend : bus.imem_req) && ($urandom_range(100, 1) <= gnt_pct);
    #1;
    if (rdr) chk("req_low_on_redirect", 32'(bus.imem_req), 0);
    if (bus.imem_gnt) begin
      live = 0;
      foreach (mem_q[i]) if (mem_q[i].live) live++;
      chk("imem_addr", bus.imem_addr, mdl_pc);
      chk("credit_ok", 32'(mem_q.size() + exp_q.size() - live - int'(instr_valid && instr_ready) < 2), 1);
      mem_q.push_back('{addr: bus.imem_addr, live: !rdr, due: cyc + $urandom_range(lat_max, lat_min)});
      if (!rdr) exp_q.push_back('{pc: mdl_pc, word: mem_word(mdl_pc)});
      mdl_pc += 4;
    end
    if (bus.imem_rvalid) void'(mem_q.pop_front());
    if (rdr) begin
      exp_q.delete();
      foreach (mem_q[i]) mem_q[i].live = 1'b0;
      mdl_pc = tgt & ~32'h3;
    end
    pend = bus.imem_req && !bus.imem_gnt && !rdr;
    cyc++;
  endtask
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask
  initial begin
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    #12;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", instr_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("req_before_first_edge", 32'(bus.imem_req), 0);
    cycle(1'b0, '0);
    chk("req_after_release", 32'(bus.imem_req), 1);
    run_cycles(4);
    snap = hs_cnt;
    run_cycles(10);
    chk("throughput", 32'(hs_cnt - snap), 10);
    rdy_pct = 0;
    cycle(1'b1, 32'h100);
    run_cycles(10);
    chk("stall_req", 32'(bus.imem_req), 0);
    chk("stall_valid", 32'(instr_valid), 1);
    chk("stall_head_pc", instr_pc, 32'h100);
    rdy_pct = 100;
    run_cycles(10);
    lat_min = 3;
    lat_max = 3;
    run_cycles(6);
    cycle(1'b1, 32'h0000_0203);
    cycle(1'b0, '0);
    chk("redirect_addr", bus.imem_addr, 32'h200);
    run_cycles(12);
    lat_min = 1;
    lat_max = 1;
    cycle(1'b1, 32'hFFFF_FFFA);
    run_cycles(10);
    rdy_pct = 75;
    gnt_pct = 70;
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99, 0) < 4)
        cycle(1'b1, $urandom_range(3, 0) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom);
      else
        cycle(1'b0, '0);
    end
    rdy_pct = 0;
    gnt_pct = 100;
    lat_max = 1;
    run_cycles(8);
    @(negedge clk);
    redirect = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.imem_req), 0);
    chk("async_rst_addr", bus.imem_addr, 32'h0);
    chk("async_rst_valid", 32'(instr_valid), 0);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_pc", instr_pc, 32'h0);
    exp_q.delete();
    mem_q.delete();
    mdl_pc = '0;
    pend = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_pct = 100;
    run_cycles(12);
    gnt_pct = 0;
    for (int i = 0; i < 50 && (exp_q.size() > 0 || mem_q.size() > 0); i++) cycle(1'b0, '0);
    chk("drained_exp", 32'(exp_q.size()), 0);
    chk("drained_mem", 32'(mem_q.size()), 0);
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
